// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Pops DATA_WIDTH-bit entries from the read side of an upstream FIFO (1-cycle
// registered read latency) and packs PACK of them into one output word that
// is offered downstream over a valid/ready handshake. A single-cycle flush
// request closes a partially filled word early and marks it with m_last.
//
// Ports
//   rclk        : single clock, all logic on its rising edge
//   rrst        : synchronous active-high reset
//   fifo_empty  : upstream FIFO empty flag
//   fifo_data   : upstream FIFO read data, valid the cycle after a pop
//   fifo_r_en   : pop request to the upstream FIFO
//   flush       : single-cycle request to emit the partially filled word
//   m_data      : packed word, first popped entry in the lowest lane
//   m_keep      : one bit per lane, set for every valid lane
//   m_last      : marks the word that closes a flush
//   m_valid     : output word valid
//   m_ready     : downstream ready
//   word_cnt    : number of accepted output words (wraps at 16 bits)
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    output logic                       fifo_r_en,
    input  logic                       flush,
    output logic [PACK*DATA_WIDTH-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [15:0]                word_cnt
);

    // Counter width able to hold the value PACK itself.
    localparam int CW  = $clog2(PACK + 1);
    localparam int CWX = CW + 1;

    localparam logic [CW-1:0] PACK_CNT = CW'(PACK);
    localparam logic [CW:0]   PACK_EXT = CWX'(PACK);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CW-1:0]             r_fill_cnt;
    logic [CW-1:0]             w_fill_nxt;
    logic [CW-1:0]             w_fill_inc;
    logic [CW:0]               w_occ;
    logic                      r_rd_pend;
    logic                      r_flush_pend;
    logic                      w_flush_pend_nxt;
    logic [PACK*DATA_WIDTH-1:0] r_m_data;
    logic [PACK*DATA_WIDTH-1:0] w_data_nxt;
    logic [PACK-1:0]           r_m_keep;
    logic [PACK-1:0]           w_keep_nxt;
    logic [PACK-1:0]           w_lane_sel;
    logic                      r_m_last;
    logic                      w_last_nxt;
    logic                      r_m_valid;
    logic                      w_valid_nxt;
    logic [15:0]               r_word_cnt;
    logic [15:0]               w_cnt_nxt;
    logic                      w_pop;

    // Lanes already captured plus the one still in flight: a pop is only
    // issued while this stays below PACK, so back-to-back pops never overrun.
    assign w_occ      = {1'b0, r_fill_cnt} + {{CW{1'b0}}, r_rd_pend};
    assign w_fill_inc = r_fill_cnt + {{(CW-1){1'b0}}, 1'b1};

    // One-hot select of the lane the in-flight entry lands in.
    always_comb begin
        w_lane_sel = {PACK{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            w_lane_sel[i] = (r_fill_cnt == CW'(i));
        end
    end

    // Next-state and next-value logic for the FILL/OUT controller.
    always_comb begin
        w_state_nxt      = r_state;
        w_fill_nxt       = r_fill_cnt;
        w_flush_pend_nxt = r_flush_pend;
        w_data_nxt       = r_m_data;
        w_keep_nxt       = r_m_keep;
        w_last_nxt       = r_m_last;
        w_valid_nxt      = r_m_valid;
        w_cnt_nxt        = r_word_cnt;
        w_pop            = 1'b0;

        case (r_state)
            ST_FILL: begin
                w_pop = !rrst && !fifo_empty && (w_occ < PACK_EXT) && !r_flush_pend;

                if (flush) begin
                    w_flush_pend_nxt = 1'b1;
                end else begin
                    w_flush_pend_nxt = r_flush_pend;
                end

                if (r_rd_pend) begin
                    // The entry popped last cycle is on fifo_data now.
                    for (int i = 0; i < PACK; i++) begin
                        w_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
                            w_lane_sel[i] ? fifo_data : r_m_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    w_keep_nxt = r_m_keep | w_lane_sel;
                    w_fill_nxt = w_fill_inc;
                    if (w_fill_inc == PACK_CNT) begin
                        // Full word; a flush pending or arriving now closes it.
                        w_state_nxt = ST_OUT;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = r_flush_pend | flush;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else if (r_flush_pend) begin
                    // No pop in flight, so the partial word is complete.
                    if (r_fill_cnt != {CW{1'b0}}) begin
                        w_state_nxt = ST_OUT;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b1;
                    end else begin
                        // Nothing to flush: drop the request without a word.
                        w_flush_pend_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end

            ST_OUT: begin
                // flush is ignored here; the word is frozen until accepted.
                if (r_m_valid && m_ready) begin
                    w_state_nxt = ST_FILL;
                    w_fill_nxt  = {CW{1'b0}};
                    w_data_nxt  = {(PACK*DATA_WIDTH){1'b0}};
                    w_keep_nxt  = {PACK{1'b0}};
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = r_word_cnt + 16'd1;
                    if (r_m_last) begin
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        w_flush_pend_nxt = r_flush_pend;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end

            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state      <= ST_FILL;
            r_fill_cnt   <= {CW{1'b0}};
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_m_data     <= {(PACK*DATA_WIDTH){1'b0}};
            r_m_keep     <= {PACK{1'b0}};
            r_m_last     <= 1'b0;
            r_m_valid    <= 1'b0;
            r_word_cnt   <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_fill_cnt   <= w_fill_nxt;
            r_rd_pend    <= w_pop;
            r_flush_pend <= w_flush_pend_nxt;
            r_m_data     <= w_data_nxt;
            r_m_keep     <= w_keep_nxt;
            r_m_last     <= w_last_nxt;
            r_m_valid    <= w_valid_nxt;
            r_word_cnt   <= w_cnt_nxt;
        end
    end

    assign fifo_r_en = w_pop;
    assign m_data    = r_m_data;
    assign m_keep    = r_m_keep;
    assign m_last    = r_m_last;
    assign m_valid   = r_m_valid;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Directed bench for fifo_rd_packer (DATA_WIDTH=8, PACK=4). A queue models
// the upstream FIFO with one-cycle read latency; expected output words are
// pushed into a scoreboard queue when their bytes are supplied, and a forked
// monitor pops and compares every accepted output word.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;

    logic          rclk;
    logic          rrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_r_en;
    logic          flush;
    logic [PK*DW-1:0] m_data;
    logic [PK-1:0] m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   word_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  fifo_q[$];
    logic        hold_empty;
    logic        pop_seen;
    int          total;
    int          bad;
    logic [31:0] rand_acc;
    logic [7:0]  rand_b;
    int          rand_sent;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    // Clock
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // A pop request seen at an edge is served by the FIFO model afterwards.
    always @(posedge rclk) pop_seen <= fifo_r_en;

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0) || hold_empty;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    // Advance to the next falling edge and serve the FIFO read data.
    task automatic step();
        @(negedge rclk);
        if (pop_seen) begin
            total++;
            if (fifo_q.size() == 0) begin
                bad++;
                $display("FAIL fifo_pop: got=pop on empty want=no pop");
            end else begin
                fifo_data = fifo_q.pop_front();
            end
        end
        refresh();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        step();
        step();
    endtask

    // Scoreboard monitor: compares every accepted output word.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge rclk);
            #2;
            if (!rrst && m_valid && m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_word: got data=%h keep=%h last=%b want=no word", m_data, m_keep, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last) begin
                        bad++;
                        $display("FAIL out_word: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                                 m_data, m_keep, m_last, e.data, e.keep, e.last);
                    end
                end
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rrst       = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        hold_empty = 1'b0;
        fifo_data  = 8'h00;
        refresh();
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) step();
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_keep", 64'(m_keep), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_cnt", 64'(word_cnt), 64'd0);

        // Preloaded 11,22,33,44: four pops, word two cycles after the last
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_exp(32'h44332211, 4'hF, 1'b0);
        #1;
        chk("rst_ren", 64'(fifo_r_en), 64'd0);
        step();
        #1;
        chk("rst_ren_hold", 64'(fifo_r_en), 64'd0);
        m_ready = 1'b1;
        rrst    = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t1_ren", 64'(fifo_r_en), 64'(k < 4));
            chk("t1_valid", 64'(m_valid), 64'(k == 5));
            step();
        end
        #1;
        chk("t1_cnt", 64'(word_cnt), 64'd1);

        // Eight bytes with ready low: first word held, no pops while held
        m_ready = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            push_byte(8'(b));
        end
        push_exp(32'h04030201, 4'hF, 1'b0);
        push_exp(32'h08070605, 4'hF, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            if (m_valid) begin
                chk("t2_hold_data", 64'(m_data), 64'h04030201);
                chk("t2_hold_ren", 64'(fifo_r_en), 64'd0);
            end
        end
        chk("t2_held_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        drain("t2");

        // AA,BB then flush: partial word with m_last
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_exp(32'h0000BBAA, 4'h3, 1'b1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("t3");

        // Flush on the cycle the third pop is issued: byte still included
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_exp(32'h00C3C2C1, 4'h7, 1'b1);
        step();
        step();
        flush = 1'b1;
        #1;
        chk("t4_third_pop", 64'(fifo_r_en), 64'd1);
        step();
        flush = 1'b0;
        drain("t4");

        // Flush with an empty packer: no word, pops blocked for one cycle only
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_byte(8'hD1);
        #1;
        chk("t5_pop_blocked", 64'(fifo_r_en), 64'd0);
        chk("t5_no_valid_a", 64'(m_valid), 64'd0);
        step();
        #1;
        chk("t5_pop_resumed", 64'(fifo_r_en), 64'd1);
        chk("t5_no_valid_b", 64'(m_valid), 64'd0);
        push_byte(8'hD2);
        push_byte(8'hD3);
        push_byte(8'hD4);
        push_exp(32'hD4D3D2D1, 4'hF, 1'b0);
        drain("t5");

        // Flush in the cycle the fourth lane lands: full word with m_last
        push_byte(8'h5A);
        push_byte(8'h6B);
        push_byte(8'h7C);
        push_byte(8'h8D);
        push_exp(32'h8D7C6B5A, 4'hF, 1'b1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("t6");
        push_byte(8'h10);
        push_byte(8'h11);
        push_byte(8'h12);
        push_byte(8'h13);
        push_exp(32'h13121110, 4'hF, 1'b0);
        drain("t6b");
        #1;
        chk("pre_rst_cnt", 64'(word_cnt), 64'd8);

        // Reset after two lanes with a third pop in flight
        push_byte(8'hE1);
        push_byte(8'hE2);
        push_byte(8'hE3);
        push_byte(8'hE4);
        repeat (3) step();
        rrst = 1'b1;
        #1;
        chk("t7_rst_ren", 64'(fifo_r_en), 64'd0);
        step();
        rrst = 1'b0;
        fifo_q.delete();
        refresh();
        #1;
        chk("t7_cnt_zero", 64'(word_cnt), 64'd0);
        chk("t7_keep_zero", 64'(m_keep), 64'd0);
        chk("t7_valid_zero", 64'(m_valid), 64'd0);
        push_byte(8'hF1);
        push_byte(8'hF2);
        push_byte(8'hF3);
        push_byte(8'hF4);
        push_exp(32'hF4F3F2F1, 4'hF, 1'b0);
        drain("t7");
        #1;
        chk("t7_cnt_one", 64'(word_cnt), 64'd1);

        // 1000 random bytes with random empty and ready patterns
        rand_sent = 0;
        rand_acc  = 32'h0;
        for (int c = 0; c < 20000 && (rand_sent < 1000 || exp_q.size() != 0); c++) begin
            hold_empty = ($urandom_range(9, 0) < 32'd3);
            m_ready    = ($urandom_range(9, 0) < 32'd7);
            if (rand_sent < 1000 && $urandom_range(1, 0) == 32'd1) begin
                rand_b = 8'($urandom_range(255, 0));
                rand_acc[(rand_sent % 4) * 8 +: 8] = rand_b;
                push_byte(rand_b);
                rand_sent++;
                if (rand_sent % 4 == 0) begin
                    push_exp(rand_acc, 4'hF, 1'b0);
                end
            end
            refresh();
            step();
        end
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        refresh();
        chk("rand_sent", 64'(rand_sent), 64'd1000);
        chk("rand_left", 64'(exp_q.size()), 64'd0);
        step();
        step();
        #1;
        chk("rand_cnt", 64'(word_cnt), 64'd251);
        chk("rand_fifo_left", 64'(fifo_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
